shift_delay_line: RTL and testbench

Parametrised multi-channel shift-register delay line with a runtime-selectable tap, per-channel shift enable, valid tracking and synchronous flush. Each channel delays a WIDTH-bit sample by 1 to DEPTH cycles of shift. A combinational bypass copy of the input is also provided. It sits between a sampling front end and downstream consumers that need per-channel alignment delays.

---
 rtl/shift_delay_line.sv | 104 ++++++++++
 tb/tb_shift_delay_line.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/shift_delay_line.sv
// rtl/shift_delay_line.sv - multi-channel shift delay line with shared clamped tap select
// Optional per-channel valid-stage count on fill_o when SHIFT_DELAY_FILL_EN is defined.
module shift_delay_line #(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 4,
  parameter int CHANNELS = 2,
  localparam int TAP_W   = $clog2(DEPTH)
`ifdef SHIFT_DELAY_FILL_EN
  , localparam int FILL_W = $clog2(DEPTH + 1)
`endif
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [CHANNELS-1:0]         shift_en_i,
  input  logic [CHANNELS*WIDTH-1:0]   data_i,
  input  logic [CHANNELS-1:0]         valid_i,
  input  logic                        flush_i,
  input  logic [TAP_W-1:0]            tap_sel_i,
  output logic [CHANNELS*WIDTH-1:0]   data_o,
  output logic [CHANNELS-1:0]         valid_o,
  output logic [CHANNELS*WIDTH-1:0]   bypass_o
`ifdef SHIFT_DELAY_FILL_EN
  , output logic [CHANNELS*FILL_W-1:0] fill_o
`endif
);

  localparam logic [TAP_W:0] MAX_TAP = (TAP_W + 1)'(DEPTH - 1);

  logic [TAP_W-1:0]             eff_tap;
  logic [DEPTH-1:0][WIDTH-1:0]  stage_q [CHANNELS];
  logic [DEPTH-1:0][WIDTH-1:0]  stage_d [CHANNELS];
  logic [DEPTH-1:0]             vld_q   [CHANNELS];
  logic [DEPTH-1:0]             vld_d   [CHANNELS];

  assign bypass_o = data_i;

  // Tap codes beyond the last stage select the last stage.
  always_comb begin
    eff_tap = ({1'b0, tap_sel_i} > MAX_TAP) ? MAX_TAP[TAP_W-1:0] : tap_sel_i;
  end

  always_comb begin
    for (int c = 0; c < CHANNELS; c++) begin
      stage_d[c] = stage_q[c];
      vld_d[c]   = vld_q[c];
      if (flush_i) begin
        stage_d[c] = '0;
        vld_d[c]   = '0;
      end else if (shift_en_i[c]) begin
        stage_d[c] = {stage_q[c][DEPTH-2:0], data_i[c*WIDTH +: WIDTH]};
        vld_d[c]   = {vld_q[c][DEPTH-2:0], valid_i[c]};
      end
    end
  end

  // Output samples the next-state tap so a shift and its output land on one edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < CHANNELS; c++) begin
        stage_q[c] <= '0;
        vld_q[c]   <= '0;
      end
      data_o  <= '0;
      valid_o <= '0;
    end else begin
      for (int c = 0; c < CHANNELS; c++) begin
        stage_q[c]                <= stage_d[c];
        vld_q[c]                  <= vld_d[c];
        data_o[c*WIDTH +: WIDTH]  <= stage_d[c][eff_tap];
        valid_o[c]                <= vld_d[c][eff_tap];
      end
    end
  end

`ifdef SHIFT_DELAY_FILL_EN
  logic [FILL_W-1:0] fill_q [CHANNELS];
  logic [FILL_W-1:0] fill_d [CHANNELS];

  // Count tracks the popcount of the valid bits, so it stays within 0..DEPTH.
  always_comb begin
    for (int c = 0; c < CHANNELS; c++) begin
      fill_d[c] = fill_q[c];
      if (flush_i)
        fill_d[c] = '0;
      else if (shift_en_i[c])
        fill_d[c] = fill_q[c] + FILL_W'(valid_i[c]) - FILL_W'(vld_q[c][DEPTH-1]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < CHANNELS; c++) fill_q[c] <= '0;
    end else begin
      for (int c = 0; c < CHANNELS; c++) fill_q[c] <= fill_d[c];
    end
  end

  always_comb begin
    fill_o = '0;
    for (int c = 0; c < CHANNELS; c++) fill_o[c*FILL_W +: FILL_W] = fill_q[c];
  end
`endif

endmodule

// File: tb/tb_shift_delay_line.sv
// tb/tb_shift_delay_line.sv - directed bench for shift_delay_line (DEPTH=4 x2 and DEPTH=6 x1)
module tb_shift_delay_line;
  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  shift_en, valid, valid_o;
  logic [15:0] data, data_o, bypass;
  logic        flush;
  logic [1:0]  tap;
  logic        s6_en, s6_valid, s6_flush, s6_valid_o;
  logic [7:0]  s6_data, s6_data_o, s6_bypass;
  logic [2:0]  s6_tap;
`ifdef SHIFT_DELAY_FILL_EN
  logic [5:0]  fill;
  logic [2:0]  s6_fill;
`endif
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  shift_delay_line #(.WIDTH(8), .DEPTH(4), .CHANNELS(2)) dut (
    .clk(clk), .rst(rst), .shift_en_i(shift_en), .data_i(data), .valid_i(valid),
    .flush_i(flush), .tap_sel_i(tap), .data_o(data_o), .valid_o(valid_o),
    .bypass_o(bypass)
`ifdef SHIFT_DELAY_FILL_EN
    , .fill_o(fill)
`endif
  );

  shift_delay_line #(.WIDTH(8), .DEPTH(6), .CHANNELS(1)) dut6 (
    .clk(clk), .rst(rst), .shift_en_i(s6_en), .data_i(s6_data), .valid_i(s6_valid),
    .flush_i(s6_flush), .tap_sel_i(s6_tap), .data_o(s6_data_o), .valid_o(s6_valid_o),
    .bypass_o(s6_bypass)
`ifdef SHIFT_DELAY_FILL_EN
    , .fill_o(s6_fill)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    check("bypass", bypass, data);
    check("bypass6", s6_bypass, s6_data);
  endtask

  task automatic do_flush();
    flush = 1'b1;
    step();
    flush = 1'b0;
  endtask

`ifdef SHIFT_DELAY_FILL_EN
  logic vpat [10] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
  int   fexp [10] = '{1, 2, 2, 3, 3, 3, 3, 3, 3, 3};
`endif

  initial begin
    rst = 1'b1; shift_en = '0; valid = '0; data = '0; flush = 1'b0; tap = '0;
    s6_en = 1'b0; s6_valid = 1'b0; s6_data = '0; s6_flush = 1'b0; s6_tap = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_data", data_o, 16'h0);
    check("rst_valid", valid_o, 2'b00);
`ifdef SHIFT_DELAY_FILL_EN
    check("rst_fill", fill, 6'h0);
`endif
    rst = 1'b0;

    // flush discards the concurrent sample and clears outputs
    tap = 2'd0; shift_en = 2'b01; valid = 2'b01; data = 16'h00A5;
    step();
    check("a5_data", data_o[7:0], 8'hA5);
    check("a5_valid", valid_o[0], 1'b1);
    flush = 1'b1; data = 16'h00FF;
    step();
    flush = 1'b0;
    check("flush_data", data_o, 16'h0);
    check("flush_valid", valid_o, 2'b00);
`ifdef SHIFT_DELAY_FILL_EN
    check("flush_fill", fill[2:0], 3'd0);
`endif

    // latency sweep: sample 0x01 must appear tap+1 edges after presentation
    for (int t = 0; t < 4; t++) begin
      tap = 2'(t);
      do_flush();
      for (int i = 1; i <= t + 2; i++) begin
        data = {8'h00, 8'(i)}; shift_en = 2'b01; valid = 2'b01;
        step();
        if (i == t && t > 0) check("lat_early_valid", valid_o[0], 1'b0);
        if (i == t + 1) begin
          check("lat_first_data", data_o[7:0], 8'h01);
          check("lat_first_valid", valid_o[0], 1'b1);
        end
        if (i == t + 2) check("lat_second_data", data_o[7:0], 8'h02);
      end
    end

    // asynchronous reset in mid-stream, then restart from empty
    data = 16'h0033;
    step();
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_data", data_o, 16'h0);
    check("async_rst_valid", valid_o, 2'b00);
    @(negedge clk);
    rst = 1'b0;
    tap = 2'd1; data = 16'h0077;
    step();
    check("post_rst_valid", valid_o[0], 1'b0);
    check("post_rst_data", data_o[7:0], 8'h00);
    data = 16'h0078;
    step();
    check("post_rst_d1", data_o[7:0], 8'h77);
    check("post_rst_v1", valid_o[0], 1'b1);

    // independent enables: ch1 shifts on every other cycle
    do_flush();
    tap = 2'd2; valid = 2'b11;
    for (int i = 0; i < 6; i++) begin
      shift_en = {(i % 2 == 0), 1'b1};
      data = {((i == 0) ? 8'h3C : 8'(8'h11 * i)), 8'(8'h50 + i)};
      step();
      if (i == 3) check("ind_ch1_early", valid_o[1], 1'b0);
      if (i == 4) begin
        check("ind_ch1_data", data_o[15:8], 8'h3C);
        check("ind_ch1_valid", valid_o[1], 1'b1);
        check("ind_ch0_data", data_o[7:0], 8'h52);
      end
      if (i == 5) begin
        check("ind_ch1_hold", data_o[15:8], 8'h3C);
        check("ind_ch0_next", data_o[7:0], 8'h53);
      end
    end

    // hold with tap change: stages stay put, tap moves next edge
    do_flush();
    tap = 2'd0; valid = 2'b01;
    for (int i = 0; i < 4; i++) begin
      shift_en = 2'b01; data = {8'h00, 8'(8'h10 * (i + 1))};
      step();
    end
    check("hold_fill40", data_o[7:0], 8'h40);
    shift_en = 2'b00; tap = 2'd3; data = 16'h00EE;
    step();
    check("hold_tap3", data_o[7:0], 8'h10);
    check("hold_tap3_valid", valid_o[0], 1'b1);
    tap = 2'd1;
    step();
    check("hold_tap1", data_o[7:0], 8'h30);
    tap = 2'd0;
    step();
    check("hold_tap0", data_o[7:0], 8'h40);

`ifdef SHIFT_DELAY_FILL_EN
    do_flush();
    shift_en = 2'b01;
    for (int i = 0; i < 10; i++) begin
      valid = {1'b0, vpat[i]}; data = {8'h00, 8'(i)};
      step();
      check("fill_count", fill[2:0], 3'(fexp[i]));
    end
    shift_en = 2'b00; valid = 2'b01;
    step();
    check("fill_hold", fill[2:0], 3'd3);
`endif

    // clamp on DEPTH=6: tap 7 behaves as delay 6
    s6_flush = 1'b1;
    step();
    s6_flush = 1'b0; s6_tap = 3'd7;
    for (int i = 1; i <= 7; i++) begin
      s6_en = 1'b1; s6_valid = 1'b1; s6_data = 8'(i);
      step();
      if (i == 5) check("clamp_early", s6_valid_o, 1'b0);
      if (i == 6) begin
        check("clamp_first", s6_data_o, 8'h01);
        check("clamp_valid", s6_valid_o, 1'b1);
      end
      if (i == 7) check("clamp_second", s6_data_o, 8'h02);
    end
    s6_en = 1'b0; s6_tap = 3'd5;
    step();
    check("clamp_tap5", s6_data_o, 8'h02);
    s6_tap = 3'd6;
    step();
    check("clamp_tap6", s6_data_o, 8'h02);
    s6_tap = 3'd4;
    step();
    check("clamp_tap4", s6_data_o, 8'h03);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
